serial_tx_scheduler: RTL and testbench

Shares one bit-serial transmit line among NUM_REQ requesters. Each requester offers a WORD_SIZE-bit word over a valid/ready handshake. The block grants requesters in round-robin order, captures the granted word, and shifts it out one bit per clock, MSB first, inside a framed packet: start bit, requester ID, payload, then idle gap. It sits between the word producers and the serial pin, replacing free-running ROM playback with on-demand scheduled transmission.

---
 rtl/serial_tx_pkg.sv | 28 ++
 rtl/serial_tx_scheduler_if.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/serial_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial transmit scheduler.
// Holds the frame FSM state enum and a small width helper.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ID,
    DATA,
    GAP
  } tx_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester-side valid/ready bundle for the serial transmit scheduler.
// req_valid/req_data from producers, one-hot req_ready back to them.
interface serial_tx_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 27
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first req above pointer, wrapping.
// Ports: req, pointer, enable in; one-hot grant, idx, hit out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          hit
);

  typedef logic [IW:0] sum_t;

  sum_t s;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    s     = '0;
    for (int i = 1; i <= N; i++) begin
      s = sum_t'(pointer) + sum_t'(i);
      if (s >= sum_t'(N)) s = s - sum_t'(N);
      if (enable && !hit && req[s[IW-1:0]]) begin
        hit               = 1'b1;
        grant[s[IW-1:0]]  = 1'b1;
        idx               = s[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler framing requester words onto one serial line.
// Ports: clock, reset, req (slave bundle), serialOut, busy, grant_id.
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int WORD_SIZE  = 27,
  parameter  int GAP_CYCLES = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_tx_scheduler_if.slave req,
  output logic                 serialOut,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam int CW =
    $clog2(max3(ID_W, WORD_SIZE, GAP_CYCLES) + 1);
  localparam int SW = ID_W + WORD_SIZE;

  localparam logic [CW-1:0] ID_LAST =
    CW'(ID_W - 1);
  localparam logic [CW-1:0] DATA_LAST =
    CW'(WORD_SIZE - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0] PTR_RST =
    ID_W'(NUM_REQ - 1);

  tx_state_t state, nstate;

  logic [CW-1:0]        cnt, cnt_nxt;
  logic [SW-1:0]        sh;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      g_idx;
  logic [NUM_REQ-1:0]   g_vec;
  logic                 hit;
  logic                 arb_en;
  logic                 ser_nxt;
  logic                 load;
  logic                 shift;
  logic [WORD_SIZE-1:0] words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign words[i] =
      req.req_data[i*WORD_SIZE +: WORD_SIZE];
  end

  // Reset gates the arbiter so no ready escapes
  // while reset is held.
  assign arb_en = (state == IDLE) && !reset;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req     (req.req_valid),
    .pointer (ptr),
    .enable  (arb_en),
    .grant   (g_vec),
    .idx     (g_idx),
    .hit     (hit)
  );

  assign req.req_ready = g_vec;
  assign busy          = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // ID and payload share one shift register, so the
  // line always takes the register MSB.
  always_comb begin
    nstate  = state;
    cnt_nxt = cnt;
    ser_nxt = IDLE_LEVEL;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          load    = 1'b1;
          ser_nxt = START_BIT;
          nstate  = START;
        end
      end
      START: begin
        ser_nxt = sh[SW-1];
        shift   = 1'b1;
        cnt_nxt = ID_LAST;
        nstate  = ID;
      end
      ID: begin
        ser_nxt = sh[SW-1];
        shift   = 1'b1;
        if (cnt == '0) begin
          cnt_nxt = DATA_LAST;
          nstate  = DATA;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_nxt = GAP_LAST;
          nstate  = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          ser_nxt = sh[SW-1];
          shift   = 1'b1;
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) nstate = IDLE;
        else           cnt_nxt = cnt - 1'b1;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      sh        <= '0;
      ptr       <= PTR_RST;
      grant_id  <= '0;
      serialOut <= IDLE_LEVEL;
    end else begin
      cnt       <= cnt_nxt;
      serialOut <= ser_nxt;
      if (load) begin
        sh       <= {g_idx, words[g_idx]};
        grant_id <= g_idx;
        ptr      <= g_idx;
      end else if (shift) begin
        sh <= {sh[SW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Self-checking bench: queue-based frame model for the default build,
// plus period/order checks on a GAP_CYCLES=0 build.
module tb_serial_tx_scheduler;

  localparam int N   = 4;
  localparam int W   = 27;
  localparam int IDW = 2;
  localparam int GP  = 1;

  logic clock = 1'b0;
  logic reset;
  logic reset1;

  always #5 clock = ~clock;

  serial_tx_scheduler_if #(.NUM_REQ(N), .WORD_SIZE(W)) bus0 ();
  serial_tx_scheduler_if #(.NUM_REQ(N), .WORD_SIZE(W)) bus1 ();

  logic           ser0, busy0, ser1, busy1;
  logic [IDW-1:0] gid0, gid1;

  serial_tx_scheduler #(
    .NUM_REQ(N), .WORD_SIZE(W), .GAP_CYCLES(GP)
  ) dut0 (
    .clock(clock), .reset(reset), .req(bus0.slave),
    .serialOut(ser0), .busy(busy0), .grant_id(gid0)
  );

  serial_tx_scheduler #(
    .NUM_REQ(N), .WORD_SIZE(W), .GAP_CYCLES(0)
  ) dut1 (
    .clock(clock), .reset(reset1), .req(bus1.slave),
    .serialOut(ser1), .busy(busy1), .grant_id(gid1)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: when the line is idle, arbitrate and queue the
  // whole frame's line levels; otherwise pop one per cycle.
  bit             exp_q[$];
  int             ptr_m = N - 1;
  logic [IDW-1:0] gid_m = '0;
  int             glog[$];
  int             gcyc[$];
  int             rdy_cnt[N];
  logic [N-1:0]   rdy_seen = '0;
  bit             auto_drop = 1'b1;

  always @(negedge clock) begin
    int             g;
    logic [N-1:0]   er;
    logic [W-1:0]   wd;
    logic [IDW-1:0] gv;
    bit             e;
    cyc++;
    rdy_seen = bus0.req_ready;
    for (int k = 0; k < N; k++)
      if (bus0.req_ready[k]) rdy_cnt[k]++;
    if (reset) begin
      chk("rst_line", ser0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_ready", bus0.req_ready, 0);
      chk("rst_gid", gid0, 0);
      exp_q.delete();
      ptr_m = N - 1;
      gid_m = '0;
    end else if (exp_q.size() == 0) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (g < 0 && bus0.req_valid[j]) g = j;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("idle_line", ser0, 0);
      chk("idle_busy", busy0, 0);
      chk("idle_ready", bus0.req_ready, er);
      chk("idle_gid", gid0, gid_m);
      if (g >= 0) begin
        ptr_m = g;
        gv    = g[IDW-1:0];
        gid_m = gv;
        wd    = bus0.req_data[g*W +: W];
        exp_q.push_back(1'b1);
        for (int b = IDW - 1; b >= 0; b--) exp_q.push_back(gv[b]);
        for (int b = W - 1; b >= 0; b--)   exp_q.push_back(wd[b]);
        for (int b = 0; b < GP; b++)       exp_q.push_back(1'b0);
        glog.push_back(g);
        gcyc.push_back(cyc);
      end
    end else begin
      e = exp_q.pop_front();
      chk("frame_line", ser0, e);
      chk("frame_busy", busy0, 1);
      chk("frame_ready", bus0.req_ready, 0);
      chk("frame_gid", gid0, gid_m);
    end
  end

  int g1_id[$];
  int g1_cyc[$];
  int cyc1  = 0;
  bit post1 = 1'b0;

  always @(negedge clock) begin
    cyc1++;
    if (!reset1) begin
      if (post1) chk("g0_start_bit", ser1, 1);
      post1 = (bus1.req_ready != '0);
      if (post1) begin
        chk("g0_grant_low", ser1, 0);
        chk("g0_onehot", $countones(bus1.req_ready), 1);
        g1_id.push_back(bus1.req_ready[1] ? 1 : 0);
        g1_cyc.push_back(cyc1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    for (int k = 0; k < N; k++) begin
      if (rdy_seen[k]) begin
        bus0.req_data[k*W +: W] = W'($urandom);
        if (auto_drop) bus0.req_valid[k] = 1'b0;
      end
    end
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] cap;
    int          bcount;
    int          c1;
    int          exp_rr[6];
    int          exp3[3];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp3   = '{0, 2, 3};

    reset  = 1'b1;
    reset1 = 1'b1;
    bus0.req_valid = 4'hF;
    bus0.req_data  = '0;
    bus1.req_valid = 4'b0011;
    bus1.req_data  = '0;
    bus1.req_data[0 +: W] = 27'h1234567;
    bus1.req_data[W +: W] = 27'h7654321;
    repeat (3) tick();
    chk("t0_ready_in_reset", bus0.req_ready, 0);
    bus0.req_valid = '0;
    reset  = 1'b0;
    reset1 = 1'b0;
    tick();

    // single requester, hand-computed frame image
    glog.delete();
    bus0.req_data[W +: W] = 27'h4000001;
    bus0.req_valid = 4'b0010;
    cap    = '0;
    bcount = 0;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i <= 30) cap = {cap[28:0], ser0};
      bcount += int'(busy0);
    end
    chk("t1_frame", cap, 30'h2C000001);
    chk("t1_busy_len", bcount, 31);
    chk("t1_grants", glog.size(), 1);
    chk("t1_ready1", rdy_cnt[1], 1);
    chk("t1_gid", gid0, 1);

    // round robin under continuous load
    reset = 1'b1;
    tick();
    reset = 1'b0;
    glog.delete();
    gcyc.delete();
    auto_drop = 1'b0;
    bus0.req_valid = 4'hF;
    repeat (165) tick();
    bus0.req_valid = '0;
    auto_drop = 1'b1;
    repeat (40) tick();
    chk("t2_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk("t2_order", glog[i], exp_rr[i]);
    for (int i = 1; i < gcyc.size(); i++)
      chk("t2_spacing", gcyc[i] - gcyc[i-1], 32);

    // late arrivals during DATA
    glog.delete();
    bus0.req_valid = 4'b0001;
    repeat (10) tick();
    bus0.req_valid[2] = 1'b1;
    tick();
    bus0.req_valid[3] = 1'b1;
    repeat (110) tick();
    chk("t3_count", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++)
      chk("t3_order", glog[i], exp3[i]);

    // withdrawn request
    glog.delete();
    c1 = rdy_cnt[1];
    bus0.req_valid = 4'b0001;
    repeat (6) tick();
    bus0.req_valid[1] = 1'b1;
    repeat (5) tick();
    bus0.req_valid[1] = 1'b0;
    repeat (40) tick();
    chk("t4_count", glog.size(), 1);
    chk("t4_no_ready1", rdy_cnt[1] - c1, 0);
    chk("t4_line_low", ser0, 0);

    // valid rises together with reset
    glog.delete();
    reset = 1'b1;
    bus0.req_valid = 4'b0100;
    #1;
    chk("t5_ready_in_reset", bus0.req_ready, 0);
    tick();
    reset = 1'b0;
    repeat (40) tick();
    chk("t5_count", glog.size(), 1);
    if (glog.size() > 0) chk("t5_first", glog[0], 2);

    // reset in the middle of DATA
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus0.req_data[0 +: W] = 27'h5A5A5A5;
    bus0.req_valid = 4'b0001;
    repeat (20) tick();
    chk("t6_bit10", ser0, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_abort_line", ser0, 0);
    chk("t6_abort_busy", busy0, 0);
    bus0.req_data[0 +: W] = 27'h2B3C4D5;
    bus0.req_valid = 4'b0011;
    tick();
    glog.delete();
    reset = 1'b0;
    repeat (70) tick();
    chk("t6_count", glog.size(), 2);
    if (glog.size() > 1) begin
      chk("t6_first", glog[0], 0);
      chk("t6_second", glog[1], 1);
    end

    // zero-gap build ran throughout
    chk("g0_enough", int'(g1_id.size() >= 10), 1);
    if (g1_id.size() > 0) chk("g0_first", g1_id[0], 0);
    for (int i = 1; i < g1_id.size(); i++) begin
      chk("g0_period", g1_cyc[i] - g1_cyc[i-1], 31);
      chk("g0_order", g1_id[i], i % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
